// File: rtl/ndrot_readout_deser_if.sv
// ----------------------------------------------------------------------------
// ndrot_readout_deser_if
//
// Word delivery channel from the NDROT readout deserialiser to the host-side
// capture logic. This is a plain valid/ready handshake. A word transfers on
// any clk edge where out_valid and out_ready are both high.
//
// Parameters:
//   WIDTH      bits per delivered word
//
// Signals:
//   out_data   completed word; slot 0 is in bit 0   (master -> slave)
//   out_valid  out_data holds an unread word        (master -> slave)
//   out_ready  consumer accepts the word this cycle (slave  -> master)
//
// Modports:
//   master     the deserialiser (producer)
//   slave      the capture logic (consumer)
// ----------------------------------------------------------------------------
interface ndrot_readout_deser_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ndrot_readout_deser.sv
// ----------------------------------------------------------------------------
// ndrot_readout_deser
//
// Downstream consumer of the NDROT cell. The block receives two
// toggle-encoded SFQ pulse streams. In each stream, every edge on the wire is
// one pulse. The streams are:
//   - the readout clock, which is a copy of what drives the NDROT clk input
//   - the NDROT q output
//
// Both streams are synchronised into the clk domain and turned into one-cycle
// events. The clock events divide time into readout slots. A q pulse inside a
// slot means the stored bit is 1. WIDTH slot bits are packed into a word,
// with slot 0 in bit 0. The word is offered on a valid/ready channel.
//
// Parameters:
//   WIDTH        bits per output word (2..32)
//   SYNC_STAGES  synchroniser flops per pulse input (2..4)
//
// Ports:
//   clk           system sampling clock, rising edge
//   rst           asynchronous active-high reset
//   pulse_clk     toggle-encoded readout clock
//   pulse_q       toggle-encoded NDROT q output
//   err_clr       one-cycle clear of the sticky error flags (and counters)
//   rd            word channel (master modport): out_data/out_valid/out_ready
//   err_multi     sticky: a slot saw two or more q pulses
//   err_orphan    sticky: a q pulse arrived while no slot was open
//   err_overflow  sticky: a word completed while the output was still occupied
//
// Optional build macro NDROT_DESER_PULSE_COUNT_EN adds two output ports:
//   clk_pulse_cnt[15:0]  count of readout-clock events
//   q_pulse_cnt[15:0]    count of q events, including orphans
// Both counters wrap modulo 2^16 and are cleared by err_clr.
// ----------------------------------------------------------------------------
module ndrot_readout_deser #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_clk,
  input  logic                  pulse_q,
  input  logic                  err_clr,
  ndrot_readout_deser_if.master rd,
  output logic                  err_multi,
  output logic                  err_orphan,
  output logic                  err_overflow
`ifdef NDROT_DESER_PULSE_COUNT_EN
  ,
  output logic [15:0]           clk_pulse_cnt,
  output logic [15:0]           q_pulse_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,   // no slot open yet since reset
    S_OPEN    // a slot is accumulating q pulses
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and edge detection.
  // The NDROT q line powers up low, so every flop resets to 0. The first real
  // toggle is then seen as an event. The event itself is registered, which
  // gives SYNC_STAGES+1 cycles from the input edge to the event.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_clk_reg;
  logic [SYNC_STAGES-1:0] sync_q_reg;
  logic                   prev_clk_reg;
  logic                   prev_q_reg;
  logic                   ev_clk_reg;
  logic                   ev_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_clk_reg <= '0;
      sync_q_reg   <= '0;
      prev_clk_reg <= 1'b0;
      prev_q_reg   <= 1'b0;
      ev_clk_reg   <= 1'b0;
      ev_q_reg     <= 1'b0;
    end else begin
      sync_clk_reg <= {sync_clk_reg[SYNC_STAGES-2:0], pulse_clk};
      sync_q_reg   <= {sync_q_reg[SYNC_STAGES-2:0], pulse_q};
      prev_clk_reg <= sync_clk_reg[SYNC_STAGES-1];
      prev_q_reg   <= sync_q_reg[SYNC_STAGES-1];
      ev_clk_reg   <= sync_clk_reg[SYNC_STAGES-1] ^ prev_clk_reg;
      ev_q_reg     <= sync_q_reg[SYNC_STAGES-1] ^ prev_q_reg;
    end
  end

  // --------------------------------------------------------------------------
  // Slot FSM, word assembly and output register
  // --------------------------------------------------------------------------
  state_t           state_reg,     state_next;
  logic             slot_bit_reg,  slot_bit_next;
  logic             q_seen_reg,    q_seen_next;
  logic [WIDTH-1:0] word_reg,      word_next;
  logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             multi_reg,     multi_next;
  logic             orphan_reg,    orphan_next;
  logic             overflow_reg,  overflow_next;

  logic             word_done;
  logic             load;
  logic             multi_evt;
  logic             orphan_evt;
  logic             overflow_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      slot_bit_reg  <= 1'b0;
      q_seen_reg    <= 1'b0;
      word_reg      <= '0;
      bit_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      multi_reg     <= 1'b0;
      orphan_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_bit_reg  <= slot_bit_next;
      q_seen_reg    <= q_seen_next;
      word_reg      <= word_next;
      bit_cnt_reg   <= bit_cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      multi_reg     <= multi_next;
      orphan_reg    <= orphan_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    slot_bit_next = slot_bit_reg;
    q_seen_next   = q_seen_reg;
    word_next     = word_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_done     = 1'b0;
    multi_evt     = 1'b0;
    orphan_evt    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (ev_clk_reg) begin
          // The first clock pulse opens slot 0. A q pulse in the same sample
          // cycle trails the clock pulse physically, so it belongs to the
          // new slot.
          state_next    = S_OPEN;
          slot_bit_next = ev_q_reg;
          q_seen_next   = ev_q_reg;
        end else if (ev_q_reg) begin
          orphan_evt = 1'b1;
        end
      end

      S_OPEN: begin
        if (ev_clk_reg) begin
          // Close the current slot and open the next one.
          word_next[bit_cnt_reg] = slot_bit_reg;
          if (bit_cnt_reg == LAST_BIT) begin
            word_done    = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
          slot_bit_next = ev_q_reg;
          q_seen_next   = ev_q_reg;
        end else if (ev_q_reg) begin
          if (q_seen_reg) begin
            multi_evt = 1'b1;
          end
          slot_bit_next = 1'b1;
          q_seen_next   = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A completed word may take the output register if it is empty, or if
    // the word currently held there is accepted on this same edge.
    load         = word_done && (!out_valid_reg || rd.out_ready);
    overflow_evt = word_done && out_valid_reg && !rd.out_ready;

    out_data_next = load ? word_next : out_data_reg;
    if (load) begin
      out_valid_next = 1'b1;
    end else if (rd.out_ready) begin
      out_valid_next = 1'b0;
    end else begin
      out_valid_next = out_valid_reg;
    end

    // Sticky flags. An error event in the same cycle as the clear wins.
    multi_next    = multi_evt    | (multi_reg    & ~err_clr);
    orphan_next   = orphan_evt   | (orphan_reg   & ~err_clr);
    overflow_next = overflow_evt | (overflow_reg & ~err_clr);
  end

  assign rd.out_data   = out_data_reg;
  assign rd.out_valid  = out_valid_reg;
  assign err_multi     = multi_reg;
  assign err_orphan    = orphan_reg;
  assign err_overflow  = overflow_reg;

`ifdef NDROT_DESER_PULSE_COUNT_EN
  // --------------------------------------------------------------------------
  // Pulse counters. They count raw events, which includes orphan q pulses.
  // A clear that coincides with an event leaves the count at 1.
  // --------------------------------------------------------------------------
  logic [15:0] clk_cnt_reg, clk_cnt_next;
  logic [15:0] q_cnt_reg,   q_cnt_next;

  always_comb begin
    clk_cnt_next = clk_cnt_reg;
    q_cnt_next   = q_cnt_reg;
    if (err_clr) begin
      clk_cnt_next = {15'd0, ev_clk_reg};
      q_cnt_next   = {15'd0, ev_q_reg};
    end else begin
      clk_cnt_next = clk_cnt_reg + {15'd0, ev_clk_reg};
      q_cnt_next   = q_cnt_reg + {15'd0, ev_q_reg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_reg <= '0;
      q_cnt_reg   <= '0;
    end else begin
      clk_cnt_reg <= clk_cnt_next;
      q_cnt_reg   <= q_cnt_next;
    end
  end

  assign clk_pulse_cnt = clk_cnt_reg;
  assign q_pulse_cnt   = q_cnt_reg;
`endif

endmodule
